sram: RTL and testbench

- Single-port 256 x 16 static RAM model with asynchronous-style active-low control strobes (chip enable, write enable, output enable) and one shared bidirectional 16-bit data bus.
- Writes are committed on the clock edge; reads are combinational onto the bus.
- Used as the storage element behind an SRAM controller and in standalone memory-interface benches.

---
 rtl/sram.sv | 137 +++++++++++++
 tb/tb_sram.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram.sv
// -----------------------------------------------------------------------------
// sram: single-port DEPTH x DATA_WIDTH static RAM model.
//
// Writes are committed on the rising clock edge. Reads are combinational onto
// the shared bidirectional data bus. All control strobes are active-low.
//
// Ports:
//   clk            system clock; all state updates on its rising edge
//   reset          synchronous, active-high; clears every word, releases bus
//   address        word address (ADDR_WIDTH bits)
//   data_in        shared data bus: sampled on write, driven on read, else Z
//   chip_enable    active-low chip select
//   write_enable   active-low write strobe (has priority over reading)
//   output_enable  active-low output enable
//   parity_error   (only with SRAM_PARITY_EN) high while a read is active and
//                  the stored word's parity disagrees with its parity bit
//
// Optional build macro: SRAM_PARITY_EN adds one even-parity bit per word and
// the parity_error output. The default build (macro undefined) has neither.
// -----------------------------------------------------------------------------
module sram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data_in,
  input  logic                  chip_enable,
  input  logic                  write_enable,
`ifdef SRAM_PARITY_EN
  input  logic                  output_enable,
  output logic                  parity_error
`else
  input  logic                  output_enable
`endif
);

  // Upper bound on legal addresses, one bit wider than the address so that
  // DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = DEPTH[ADDR_WIDTH:0];

  // Even parity of a data word: the bit that makes the total count of ones
  // (word plus parity bit) even.
  function automatic logic even_parity(input logic [DATA_WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
`ifdef SRAM_PARITY_EN
  logic                  par_r [DEPTH];
`endif

  logic                  in_range_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // Address range check; only matters when DEPTH < 2**ADDR_WIDTH.
  always_comb begin
    in_range_s = 1'b0;
    if ({1'b0, address} < DEPTH_LIMIT) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
  end

  // Strobe decode. Comparisons are written as "== 0" inside if/else so that
  // an X/Z on a control input falls through to the inactive branch.
  always_comb begin
    wr_en_s = 1'b0;
    rd_en_s = 1'b0;
    if (reset == 1'b0 && chip_enable == 1'b0 && write_enable == 1'b0) begin
      wr_en_s = in_range_s;
    end else begin
      wr_en_s = 1'b0;
    end
    // Write strobe low always blocks driving, so an external writer never
    // sees contention regardless of output_enable.
    if (reset == 1'b0 && chip_enable == 1'b0 && write_enable == 1'b1 &&
        output_enable == 1'b0) begin
      rd_en_s = 1'b1;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Read data mux; out-of-range reads return zero.
  always_comb begin
    rd_data_s = {DATA_WIDTH{1'b0}};
    if (rd_en_s && in_range_s) begin
      rd_data_s = mem_r[address];
    end else begin
      rd_data_s = {DATA_WIDTH{1'b0}};
    end
  end

  // Tri-state bus driver.
  assign data_in = rd_en_s ? rd_data_s : {DATA_WIDTH{1'bz}};

  // Memory array: reset clears every word and overrides a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[address] <= data_in;
    end
  end

`ifdef SRAM_PARITY_EN
  // Parity storage, written alongside the data word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        par_r[i] <= 1'b0;
      end
    end else if (wr_en_s) begin
      par_r[address] <= even_parity(data_in);
    end
  end

  // Parity check on the word currently being read.
  always_comb begin
    parity_error = 1'b0;
    if (rd_en_s && in_range_s) begin
      parity_error = even_parity(mem_r[address]) ^ par_r[address];
    end else begin
      parity_error = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sram.sv
// -----------------------------------------------------------------------------
// tb_sram: scoreboard bench for sram. Stimulus tasks push the expected bus
// response into a queue and raise sample_req; a monitor on the falling clock
// edge pops the queue and compares against the bus.
// -----------------------------------------------------------------------------
module tb_sram;

  localparam int AW = 8;
  localparam int DW = 16;

  // Kinds of expectation carried in the scoreboard.
  localparam logic [1:0] K_VALUE    = 2'd0;  // bus must equal exp
  localparam logic [1:0] K_RELEASED = 2'd1;  // RAM must not drive the bus
  localparam logic [1:0] K_PARITY   = 2'd2;  // parity_error must equal exp[0]

  typedef struct {
    logic [1:0]    kind;
    logic [DW-1:0] exp;
    string         name;
  } exp_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          chip_enable;
  logic          write_enable;
  logic          output_enable;
  logic          tb_drive_en;
  logic [DW-1:0] tb_drive_val;
  wire  [DW-1:0] data_bus;
`ifdef SRAM_PARITY_EN
  logic          parity_error;
`endif

  logic          sample_req;
  exp_t          sb_q[$];
  int            tests_run;
  int            tests_failed;

  assign data_bus = tb_drive_en ? tb_drive_val : {DW{1'bz}};

  sram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .data_in      (data_bus),
    .chip_enable  (chip_enable),
    .write_enable (write_enable),
`ifdef SRAM_PARITY_EN
    .output_enable(output_enable),
    .parity_error (parity_error)
`else
    .output_enable(output_enable)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare whenever the stimulus marks the bus as presenting a result.
  always @(negedge clk) begin
    if (sample_req) begin
      exp_t e;
      tests_run++;
      if (sb_q.size() == 0) begin
        tests_failed++;
        $display("FAIL scoreboard_empty: sample requested with no expectation");
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_VALUE: begin
            if (data_bus !== e.exp) begin
              tests_failed++;
              $display("FAIL %s: bus=%h expected=%h", e.name, data_bus, e.exp);
            end
          end
          K_RELEASED: begin
            // Undriven bus reads as Z (4-state) or 0 (2-state); the addressed
            // word is always nonzero so an erroneous drive is visible.
            if (!($isunknown(data_bus) || data_bus == {DW{1'b0}})) begin
              tests_failed++;
              $display("FAIL %s: bus=%h expected=released(Z)", e.name, data_bus);
            end
          end
`ifdef SRAM_PARITY_EN
          K_PARITY: begin
            if (parity_error !== e.exp[0]) begin
              tests_failed++;
              $display("FAIL %s: parity_error=%b expected=%b", e.name,
                       parity_error, e.exp[0]);
            end
          end
`endif
          default: begin
            tests_failed++;
            $display("FAIL %s: unknown expectation kind %0d", e.name, e.kind);
          end
        endcase
      end
    end
  end

  // Push an expectation and hold sample_req across the next falling edge.
  task automatic expect_now(input logic [1:0] kind, input logic [DW-1:0] exp,
                            input string name);
    exp_t e;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb_q.push_back(e);
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ctrl(input logic ce, input logic we, input logic oe,
                          input logic [AW-1:0] addr);
    chip_enable   = ce;
    write_enable  = we;
    output_enable = oe;
    address       = addr;
  endtask

  // One clocked write with the bench driving the bus.
  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] val);
    set_ctrl(1'b0, 1'b0, 1'b1, addr);
    tb_drive_val = val;
    tb_drive_en  = 1'b1;
    @(posedge clk);
    #1;
    tb_drive_en  = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b1, addr);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] exp,
                         input string name);
    tb_drive_en = 1'b0;
    set_ctrl(1'b0, 1'b1, 1'b0, addr);
    expect_now(K_VALUE, exp, name);
    set_ctrl(1'b1, 1'b1, 1'b1, addr);
  endtask

  // Watchdog: the stimulus is linear, so this only fires on a broken run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sample_req   = 1'b0;
    tb_drive_en  = 1'b0;
    tb_drive_val = 16'h0000;
    reset        = 1'b1;
    set_ctrl(1'b1, 1'b1, 1'b1, 8'd0);

    // One-edge reset, then the array reads zero.
    @(posedge clk);
    #1;
    reset = 1'b0;
    do_read(8'd242, 16'd0, "reset_addr242");
    do_read(8'd0,   16'd0, "reset_addr0");

    // Write 24 to 28; bench value 26 is present but not driven during the read.
    do_write(8'd28, 16'd24);
    tb_drive_val = 16'd26;
    @(posedge clk);
    #1;
    do_read(8'd28, 16'd24, "read28_first");

    // Overwrite and check an untouched location.
    do_write(8'd28, 16'd30);
    do_read(8'd28,  16'd30, "read28_overwrite");
    do_read(8'd242, 16'd0,  "read242_untouched");

    // Boundary address.
    do_write(8'd255, 16'hA5C3);
    do_read(8'd255, 16'hA5C3, "read255_top");

    // Bus release cases on address 28 (holds 30).
    tb_drive_en = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b0, 8'd28);
    expect_now(K_RELEASED, 16'd0, "release_ce_high");
    set_ctrl(1'b0, 1'b1, 1'b1, 8'd28);
    expect_now(K_RELEASED, 16'd0, "release_oe_high");

    // CE=0, WE=0, OE=0: the bench owns the bus and its value is written.
    set_ctrl(1'b0, 1'b0, 1'b0, 8'd40);
    tb_drive_val = 16'h5A5A;
    tb_drive_en  = 1'b1;
    expect_now(K_VALUE, 16'h5A5A, "bus_we_low_oe_low");
    tb_drive_en  = 1'b0;
    do_read(8'd40, 16'h5A5A, "read40_after_we_oe_low");

    // Reset mid-operation: 5 written first, then reset on the edge of a write to 6.
    do_write(8'd5, 16'hBEEF);
    do_read(8'd5, 16'hBEEF, "read5_before_reset");
    reset = 1'b1;
    set_ctrl(1'b0, 1'b1, 1'b0, 8'd5);
    sb_q.push_back('{K_RELEASED, 16'd0, "release_during_reset"});
    sample_req = 1'b1;
    @(negedge clk);
    #1;
    sample_req   = 1'b0;
    set_ctrl(1'b0, 1'b0, 1'b1, 8'd6);
    tb_drive_val = 16'h1234;
    tb_drive_en  = 1'b1;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    tb_drive_en = 1'b0;
    set_ctrl(1'b1, 1'b1, 1'b1, 8'd6);
    do_read(8'd5, 16'd0, "read5_after_reset");
    do_read(8'd6, 16'd0, "read6_after_reset");
    do_read(8'd28, 16'd0, "read28_after_reset");

`ifdef SRAM_PARITY_EN
    do_write(8'd10, 16'h0001);
    set_ctrl(1'b0, 1'b1, 1'b0, 8'd10);
    expect_now(K_PARITY, 16'd0, "parity_clean");
    dut.par_r[10] = ~dut.par_r[10];
    set_ctrl(1'b0, 1'b1, 1'b0, 8'd10);
    expect_now(K_PARITY, 16'd1, "parity_corrupt");
    set_ctrl(1'b1, 1'b1, 1'b1, 8'd10);
`endif

    // Every expectation must have been consumed by the monitor.
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
